// File: rtl/fetch_pkg.sv
// Shared fetch-side definitions. Instruction memory and decode use these too.
package fetch_pkg;
    localparam int unsigned PC_W     = 4;
    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned RESET_PC = 0;

    typedef logic [PC_W-1:0]    pc_t;
    typedef logic [INSTR_W-1:0] instr_t;
endpackage

// File: rtl/fetch_pc_reg.sv
// PC register with its next-PC selection: reset, redirect, increment or hold.
module fetch_pc_reg #(
    parameter int unsigned PC_W     = fetch_pkg::PC_W,
    parameter int unsigned RESET_PC = fetch_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect,
    input  logic [PC_W-1:0] target,
    input  logic            advance,
    output logic [PC_W-1:0] pc
);
    // Increment wraps naturally at 2^PC_W.
    always_ff @(posedge clk) begin
        if (reset)
            pc <= PC_W'(RESET_PC);
        else if (redirect)
            pc <= target;
        else if (advance)
            pc <= pc + 1'b1;
    end
endmodule

// File: rtl/fetch_unit.sv
// Single-register fetch stage: PC drives instruction memory, returned word is
// captured into the decode-facing output register with a valid/ready handshake.
module fetch_unit #(
    parameter int unsigned PC_W     = fetch_pkg::PC_W,
    parameter int unsigned INSTR_W  = fetch_pkg::INSTR_W,
    parameter int unsigned RESET_PC = fetch_pkg::RESET_PC
) (
    input  logic               clk,
    input  logic               reset,
    output logic [PC_W-1:0]    PC_out,
    input  logic [INSTR_W-1:0] IR_out,
    input  logic               branch_valid,
    input  logic [PC_W-1:0]    branch_target,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc
);
    logic load;

    assign load = !instr_valid || instr_ready;

    fetch_pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .reset    (reset),
        .redirect (branch_valid),
        .target   (branch_target),
        .advance  (load),
        .pc       (PC_out)
    );

    // A redirect kills both the held instruction and this cycle's fetch; the
    // payload is left as-is since it is invisible while instr_valid is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else if (branch_valid) begin
            instr_valid <= 1'b0;
        end else if (load) begin
            instr_valid <= 1'b1;
            instr       <= IR_out;
            instr_pc    <= PC_out;
        end
    end
endmodule
